// File: rtl/cpu_types_pkg.sv
// Shared pipeline types: per-latch command encoding and register index width.
// Used by hazard control and the pipeline latches it drives.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        PIPE_NORMAL = 2'd0,
        PIPE_STALL  = 2'd1,
        PIPE_FLUSH  = 2'd2
    } pipe_state_t;

    typedef logic [4:0] regbits_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones, synchronous active-high clear.
// One-cycle latency from inc to count; no backpressure.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + ONE;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard control: drives latch commands, PC enable/select and perf counters.
// Latch commands are combinational (zero latency); FSM state and counters update at posedge CLK.
module hazard_unit
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             dREN_mem,
    input  logic             dWEN_mem,
    input  logic             halt_mem,
    input  logic             redirect_mem,
    input  logic             dREN_ex,
    input  regbits_t         regWSEL_ex,
    input  regbits_t         rs_dec,
    input  regbits_t         rt_dec,
    output pipe_state_t      fd_state,
    output pipe_state_t      de_state,
    output pipe_state_t      em_state,
    output pipe_state_t      mw_state,
    output logic             pc_en,
    output logic             pc_sel,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        HALTED = 2'd2
    } hu_state_t;

    hu_state_t state_q;
    hu_state_t state_d;

    logic mem_wait;
    logic load_use;
    logic take_redirect;
    logic stall_inc;

    assign mem_wait = (dREN_mem | dWEN_mem) & ~dhit;
    assign load_use = dREN_ex & (regWSEL_ex != '0) &
                      ((regWSEL_ex == rs_dec) | (regWSEL_ex == rt_dec));

    // DWAIT needs no rule of its own: once dhit rises mem_wait drops and the
    // completing cycle falls through to the normal priority chain.
    always_comb begin
        fd_state      = PIPE_NORMAL;
        de_state      = PIPE_NORMAL;
        em_state      = PIPE_NORMAL;
        mw_state      = PIPE_NORMAL;
        pc_en         = 1'b1;
        pc_sel        = 1'b0;
        state_d       = RUN;
        take_redirect = 1'b0;
        if (RST) begin
            fd_state = PIPE_FLUSH;
            de_state = PIPE_FLUSH;
            em_state = PIPE_FLUSH;
            mw_state = PIPE_FLUSH;
            pc_en    = 1'b0;
        end else if (state_q == HALTED) begin
            fd_state = PIPE_STALL;
            de_state = PIPE_STALL;
            em_state = PIPE_STALL;
            mw_state = PIPE_STALL;
            pc_en    = 1'b0;
            state_d  = HALTED;
        end else if (mem_wait) begin
            fd_state = PIPE_STALL;
            de_state = PIPE_STALL;
            em_state = PIPE_STALL;
            mw_state = PIPE_STALL;
            pc_en    = 1'b0;
            state_d  = DWAIT;
        end else if (halt_mem) begin
            fd_state = PIPE_FLUSH;
            de_state = PIPE_FLUSH;
            em_state = PIPE_FLUSH;
            pc_en    = 1'b0;
            state_d  = HALTED;
        end else if (redirect_mem) begin
            fd_state      = PIPE_FLUSH;
            de_state      = PIPE_FLUSH;
            em_state      = PIPE_FLUSH;
            pc_sel        = 1'b1;
            take_redirect = 1'b1;
        end else if (load_use) begin
            fd_state = PIPE_STALL;
            de_state = PIPE_FLUSH;
            pc_en    = 1'b0;
        end else if (!ihit) begin
            fd_state = PIPE_FLUSH;
            pc_en    = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= RUN;
            halted  <= 1'b0;
        end else begin
            state_q <= state_d;
            halted  <= (state_d == HALTED);
        end
    end

    assign stall_inc = ~RST & (state_q != HALTED) & ~pc_en;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (take_redirect),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: a 32-bit and a 2-bit counter instance share stimulus.
module tb_hazard_unit;
    import cpu_types_pkg::*;

    localparam logic [1:0] N = 2'd0;
    localparam logic [1:0] S = 2'd1;
    localparam logic [1:0] F = 2'd2;

    logic        CLK = 1'b0;
    logic        RST, ihit, dhit, dREN_mem, dWEN_mem, halt_mem, redirect_mem, dREN_ex;
    regbits_t    regWSEL_ex, rs_dec, rt_dec;

    pipe_state_t fd_state, de_state, em_state, mw_state;
    logic        pc_en, pc_sel, halted;
    logic [31:0] stall_cnt, flush_cnt;

    pipe_state_t fd2, de2, em2, mw2;
    logic        pc_en2, pc_sel2, halted2;
    logic [1:0]  stall_cnt2, flush_cnt2;

    always #5 CLK = ~CLK;

    hazard_unit #(.CNT_W(32)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .dREN_mem(dREN_mem), .dWEN_mem(dWEN_mem), .halt_mem(halt_mem),
        .redirect_mem(redirect_mem), .dREN_ex(dREN_ex), .regWSEL_ex(regWSEL_ex),
        .rs_dec(rs_dec), .rt_dec(rt_dec),
        .fd_state(fd_state), .de_state(de_state), .em_state(em_state), .mw_state(mw_state),
        .pc_en(pc_en), .pc_sel(pc_sel), .halted(halted),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_unit #(.CNT_W(2)) dut2 (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .dREN_mem(dREN_mem), .dWEN_mem(dWEN_mem), .halt_mem(halt_mem),
        .redirect_mem(redirect_mem), .dREN_ex(dREN_ex), .regWSEL_ex(regWSEL_ex),
        .rs_dec(rs_dec), .rt_dec(rt_dec),
        .fd_state(fd2), .de_state(de2), .em_state(em2), .mw_state(mw2),
        .pc_en(pc_en2), .pc_sel(pc_sel2), .halted(halted2),
        .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
    );

    typedef struct {
        logic [1:0]  fd, de, em, mw;
        logic        pc_en, pc_sel, halted;
        logic [31:0] scnt, fcnt;
        logic [1:0]  scnt2;
    } exp_t;

    exp_t        sb[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    int          m_state = 0;   // 0 RUN, 1 DWAIT, 2 HALTED
    int          m_nxt;
    logic        m_flinc;
    logic [31:0] m_scnt = 0, m_fcnt = 0;
    logic [1:0]  m_scnt2 = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    task automatic predict(output exp_t e);
        logic mem_wait, lu;
        mem_wait = (dREN_mem || dWEN_mem) && !dhit;
        lu = dREN_ex && (regWSEL_ex != 0) && (regWSEL_ex == rs_dec || regWSEL_ex == rt_dec);
        e.fd = N; e.de = N; e.em = N; e.mw = N;
        e.pc_en = 1'b1; e.pc_sel = 1'b0;
        e.halted = (m_state == 2);
        e.scnt = m_scnt; e.fcnt = m_fcnt; e.scnt2 = m_scnt2;
        m_nxt = 0; m_flinc = 1'b0;
        if (RST) begin
            e.fd = F; e.de = F; e.em = F; e.mw = F; e.pc_en = 1'b0;
        end else if (m_state == 2) begin
            e.fd = S; e.de = S; e.em = S; e.mw = S; e.pc_en = 1'b0; m_nxt = 2;
        end else if (mem_wait) begin
            e.fd = S; e.de = S; e.em = S; e.mw = S; e.pc_en = 1'b0; m_nxt = 1;
        end else if (halt_mem) begin
            e.fd = F; e.de = F; e.em = F; e.pc_en = 1'b0; m_nxt = 2;
        end else if (redirect_mem) begin
            e.fd = F; e.de = F; e.em = F; e.pc_sel = 1'b1; m_flinc = 1'b1;
        end else if (lu) begin
            e.fd = S; e.de = F; e.pc_en = 1'b0;
        end else if (!ihit) begin
            e.fd = F; e.pc_en = 1'b0;
        end
    endtask

    // One cycle: inputs already driven after a negedge; compare, then advance the model.
    task automatic tick();
        exp_t e, o;
        predict(e);
        sb.push_back(e);
        #1;
        o = sb.pop_front();
        check("fd_state",  32'(fd_state),   32'(o.fd));
        check("de_state",  32'(de_state),   32'(o.de));
        check("em_state",  32'(em_state),   32'(o.em));
        check("mw_state",  32'(mw_state),   32'(o.mw));
        check("pc_en",     32'(pc_en),      32'(o.pc_en));
        check("pc_sel",    32'(pc_sel),     32'(o.pc_sel));
        check("halted",    32'(halted),     32'(o.halted));
        check("stall_cnt", stall_cnt,       o.scnt);
        check("flush_cnt", flush_cnt,       o.fcnt);
        check("stall_cnt2", 32'(stall_cnt2), 32'(o.scnt2));
        @(posedge CLK);
        if (RST) begin
            m_state = 0; m_scnt = 0; m_fcnt = 0; m_scnt2 = 0;
        end else begin
            if (m_state != 2 && !o.pc_en) begin
                if (m_scnt != 32'hFFFF_FFFF) m_scnt = m_scnt + 1;
                if (m_scnt2 != 2'd3) m_scnt2 = m_scnt2 + 2'd1;
            end
            if (m_flinc && m_fcnt != 32'hFFFF_FFFF) m_fcnt = m_fcnt + 1;
            m_state = m_nxt;
        end
        @(negedge CLK);
    endtask

    task automatic idle();
        RST = 1'b0; ihit = 1'b1; dhit = 1'b1;
        dREN_mem = 1'b0; dWEN_mem = 1'b0; halt_mem = 1'b0; redirect_mem = 1'b0;
        dREN_ex = 1'b0; regWSEL_ex = 5'd0; rs_dec = 5'd1; rt_dec = 5'd2;
    endtask

    initial begin
        idle();
        RST = 1'b1;
        @(negedge CLK);
        @(negedge CLK);

        // reset held two cycles, then a normal cycle
        tick(); tick();
        RST = 1'b0; tick();

        // data wait: three stalled cycles then completion
        dREN_mem = 1'b1; dhit = 1'b0;
        repeat (3) tick();
        dhit = 1'b1; tick();
        idle();
        check("dwait_stall_cnt", stall_cnt, 32'd3);

        // load-use, then the load reaches memory and the hazard clears
        dREN_ex = 1'b1; regWSEL_ex = 5'd5; rt_dec = 5'd5; tick();
        dREN_ex = 1'b0; dREN_mem = 1'b1; dhit = 1'b1; tick();
        idle();
        dREN_ex = 1'b1; regWSEL_ex = 5'd0; rs_dec = 5'd0; rt_dec = 5'd0; tick();
        idle();

        // redirect beats fetch miss and load-use
        redirect_mem = 1'b1; ihit = 1'b0; tick();
        idle();
        check("redirect_flush_cnt", flush_cnt, 32'd1);
        redirect_mem = 1'b1; dREN_ex = 1'b1; regWSEL_ex = 5'd7; rs_dec = 5'd7; tick();
        idle();

        // halt with redirect: halt wins, then everything ignored until reset
        halt_mem = 1'b1; redirect_mem = 1'b1; tick();
        idle();
        dREN_mem = 1'b1; dhit = 1'b0; redirect_mem = 1'b1; ihit = 1'b0;
        repeat (3) tick();
        check("halt_flush_cnt", flush_cnt, 32'd2);
        check("halt_sticky", 32'(halted), 32'd1);
        idle();
        RST = 1'b1; tick();
        idle(); tick();

        // counter saturation on the 2-bit instance
        ihit = 1'b0;
        repeat (6) tick();
        idle();
        check("sat_stall_cnt2", 32'(stall_cnt2), 32'd3);
        check("sat_stall_cnt", stall_cnt, 32'd6);

        // random mix, register indices kept small so hazards collide often
        repeat (400) begin
            RST          = ($urandom_range(0, 39) == 0);
            ihit         = ($urandom_range(0, 3) != 0);
            dhit         = ($urandom_range(0, 2) != 0);
            dREN_mem     = ($urandom_range(0, 4) == 0);
            dWEN_mem     = ($urandom_range(0, 7) == 0);
            halt_mem     = ($urandom_range(0, 59) == 0);
            redirect_mem = ($urandom_range(0, 9) == 0);
            dREN_ex      = ($urandom_range(0, 2) == 0);
            regWSEL_ex   = 5'($urandom_range(0, 3));
            rs_dec       = 5'($urandom_range(0, 3));
            rt_dec       = 5'($urandom_range(0, 3));
            tick();
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline control block that drives the four latch-state selects (fd_state, de_state, em_state, mw_state) consumed by the fetch-decode, decode-execute, execute-memory and memory-writeback latches, plus the PC enable and redirect select. It resolves data-memory wait stalls, load-use hazards, instruction-fetch misses, taken branches and jumps resolved in the memory stage, and halt drain. It holds a small FSM and two performance counters.

## Interface
Parameters:
- CNT_W, 32, width of the stall and flush performance counters

Ports:
- CLK  in  1  system clock; all state updates on the rising edge
- RST  in  1  reset, synchronous, active-high
- ihit  in  1  instruction fetch for current PC complete this cycle
- dhit  in  1  data access in memory stage complete this cycle
- dREN_mem, dWEN_mem  in  1 each  memory-stage data read/write request
- halt_mem  in  1  halt instruction in memory stage
- redirect_mem  in  1  taken branch or jump resolved in memory stage
- dREN_ex  in  1  execute-stage instruction is a load
- regWSEL_ex  in  5 (regbits_t)  execute-stage destination register
- rs_dec, rt_dec  in  5 (regbits_t)  decode-stage source registers
- fd_state, de_state, em_state, mw_state  out  pipe_state_t  per-latch command
- pc_en  out  1  PC register loads next value
- pc_sel  out  1  1 = load redirect target, 0 = PC+4
- halted  out  1  FSM in HALTED
- stall_cnt  out  CNT_W  cycles with pc_en=0 while not halted
- flush_cnt  out  CNT_W  number of redirects taken

## Operation
- pipe_state_t values: PIPE_NORMAL (latch loads), PIPE_STALL (latch holds), PIPE_FLUSH (latch loads bubble: all control bits 0).
- FSM states: RUN, DWAIT, HALTED.
- Outputs are combinational from current state and inputs. Conditions are evaluated in this priority order; the first match wins:
  1. RST=1: all four latches FLUSH, pc_en=0, pc_sel=0.
  2. HALTED: all four latches STALL, pc_en=0.
  3. Memory wait, (dREN_mem|dWEN_mem)&!dhit: all four latches STALL, pc_en=0. Next state DWAIT.
  4. halt_mem: fd/de/em FLUSH, mw NORMAL, pc_en=0. Next state HALTED.
  5. redirect_mem: fd/de/em FLUSH, mw NORMAL, pc_en=1, pc_sel=1. This applies regardless of ihit; flush_cnt increments.
  6. Load-use, dREN_ex & regWSEL_ex!=0 & (regWSEL_ex==rs_dec | regWSEL_ex==rt_dec): fd STALL, de FLUSH, em/mw NORMAL, pc_en=0.
  7. Fetch miss, !ihit: fd FLUSH, de/em/mw NORMAL, pc_en=0.
  8. Otherwise: all latches NORMAL, pc_en=1, pc_sel=0.
- DWAIT leaves to RUN in the cycle dhit=1. That cycle is evaluated from rule 4 down, so the completing access advances normally.
- A memory request with dhit=1 in the same cycle never enters DWAIT.
- stall_cnt increments when pc_en=0, RST=0 and the FSM is not HALTED. It saturates at all-ones; flush_cnt saturates the same way.
- HALTED is left only by reset.

## Timing
- Latch-state outputs have zero latency: combinational in the same cycle as their inputs.
- State and counters update at posedge CLK.
- Reset: state RUN, stall_cnt=0, flush_cnt=0, halted=0. Outputs while RST=1 are per rule 1.
- RST asserted mid-DWAIT or mid-halt returns to RUN on the next edge. No counter increments on a reset edge.
- Load-use stall lasts exactly one cycle. On the next cycle the load has moved to memory, the hazard clears, and forwarding/writeback supplies the value.
- redirect_mem during load-use or fetch miss: redirect wins, and the bubble replaces the hazard.
- halt_mem together with redirect_mem: halt wins and flush_cnt does not increment.

## Structure
- pipe_state_t (2-bit enum: PIPE_NORMAL=0, PIPE_STALL=1, PIPE_FLUSH=2) and regbits_t live in cpu_types_pkg. The FSM state enum is local to the block.
- One sub-module, sat_counter (parameter W; inputs CLK, RST, inc; output count), is instantiated twice for stall_cnt and flush_cnt.
- The outputs connect to the existing pipeline interface's state signals.

## Test plan
- Reset: RST=1 for 2 cycles -> all latches FLUSH, pc_en=0, counters 0. RST=0 with ihit=1 -> all NORMAL, pc_en=1.
- Data wait: dREN_mem=1, dhit=0 for 3 cycles, then dhit=1 -> 3 cycles of all-STALL with state DWAIT, then all NORMAL; stall_cnt=3.
- Load-use: dREN_ex=1, regWSEL_ex=5, rt_dec=5 -> fd STALL, de FLUSH, pc_en=0 for 1 cycle. Same stimulus with regWSEL_ex=0 -> no stall.
- Redirect with fetch miss: redirect_mem=1, ihit=0 -> fd/de/em FLUSH, pc_en=1, pc_sel=1, flush_cnt 0->1.
- Halt: halt_mem=1 -> mw NORMAL, others FLUSH. Following cycles -> halted=1, all STALL; dREN_mem/redirect stimuli ignored until RST.
- Saturation: set CNT_W=2 and hold !ihit for 6 cycles -> stall_cnt stops at 3.
